// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART 8N1 transmitter between two byte requesters.
// The bit period is chosen per frame from baud_rate, which is latched at accept.
module uart_tx_arbiter #(
  parameter int DIV48 = 7500,
  parameter int CNT_W = 13
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] baud_rate,
  input  logic [7:0] s0_data,
  input  logic       s0_valid,
  output logic       s0_ready,
  input  logic [7:0] s1_data,
  input  logic       s1_valid,
  output logic       s1_ready,
  output logic       tx,
  output logic       busy,
  output logic       grant,
  output logic       frame_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_DIV48 = CNT_W'(DIV48);
  localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_ZERO  = {CNT_W{1'b0}};

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_tx;
  logic             r_busy;
  logic             r_grant;
  logic             r_frame_done;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_div_nxt;
  logic [CNT_W-1:0] w_div_sel;
  logic [2:0]       w_bit_nxt;
  logic [7:0]       w_shift_nxt;
  logic             w_tx_nxt;
  logic             w_grant_nxt;
  logic             w_rdy0;
  logic             w_rdy1;
  logic             w_last;
  logic             w_fd_nxt;
  logic             w_busy_nxt;

  assign w_div_sel = C_DIV48 >> baud_rate;
  assign w_last    = (r_cnt == (r_div - C_ONE));

  // Round-robin arbitration: on contention the port that did not own the last frame wins.
  always_comb begin
    w_rdy0 = 1'b0;
    w_rdy1 = 1'b0;
    if (r_state == S_IDLE) begin
      if (s0_valid && s1_valid) begin
        if (r_grant) begin
          w_rdy0 = 1'b1;
        end else begin
          w_rdy1 = 1'b1;
        end
      end else if (s0_valid) begin
        w_rdy0 = 1'b1;
      end else if (s1_valid) begin
        w_rdy1 = 1'b1;
      end else begin
        w_rdy0 = 1'b0;
        w_rdy1 = 1'b0;
      end
    end else begin
      w_rdy0 = 1'b0;
      w_rdy1 = 1'b0;
    end
  end

  // Frame sequencer next-state logic; the shift register walks the byte LSB first.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_div_nxt   = r_div;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_grant_nxt = r_grant;
    case (r_state)
      S_IDLE: begin
        w_tx_nxt  = 1'b1;
        w_cnt_nxt = C_ZERO;
        w_bit_nxt = 3'd0;
        if (w_rdy0) begin
          w_shift_nxt = s0_data;
          w_grant_nxt = 1'b0;
          w_div_nxt   = w_div_sel;
          w_state_nxt = S_START;
          w_tx_nxt    = 1'b0;
        end else if (w_rdy1) begin
          w_shift_nxt = s1_data;
          w_grant_nxt = 1'b1;
          w_div_nxt   = w_div_sel;
          w_state_nxt = S_START;
          w_tx_nxt    = 1'b0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        if (w_last) begin
          w_cnt_nxt   = C_ZERO;
          w_state_nxt = S_DATA;
          w_tx_nxt    = r_shift[0];
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end
      S_DATA: begin
        if (w_last) begin
          w_cnt_nxt = C_ZERO;
          if (r_bit == 3'd7) begin
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_nxt   = r_bit + 3'd1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_tx_nxt    = r_shift[1];
          end
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end
      S_STOP: begin
        w_tx_nxt = 1'b1;
        if (w_last) begin
          w_cnt_nxt   = C_ZERO;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = C_ZERO;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  // frame_done and busy are computed one cycle ahead so both leave the block registered.
  assign w_fd_nxt   = (w_state_nxt == S_STOP) && (w_cnt_nxt == (w_div_nxt - C_ONE));
  assign w_busy_nxt = (w_state_nxt != S_IDLE);

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_cnt        <= C_ZERO;
      r_div        <= C_ZERO;
      r_bit        <= 3'd0;
      r_shift      <= 8'd0;
      r_tx         <= 1'b1;
      r_busy       <= 1'b0;
      r_grant      <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_div        <= w_div_nxt;
      r_bit        <= w_bit_nxt;
      r_shift      <= w_shift_nxt;
      r_tx         <= w_tx_nxt;
      r_busy       <= w_busy_nxt;
      r_grant      <= w_grant_nxt;
      r_frame_done <= w_fd_nxt;
    end
  end

  assign s0_ready   = w_rdy0;
  assign s1_ready   = w_rdy1;
  assign tx         = r_tx;
  assign busy       = r_busy;
  assign grant      = r_grant;
  assign frame_done = r_frame_done;

endmodule
